bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have no parameters; data widths are fixed at 8-bit binary in and 3 BCD digits out.
REQ-002 clk  input  1  clock; all registers SHALL update on the rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 init  input  1  start request, sampled only in IDLE; driven by the upstream multiplier done pulse.
REQ-005 bin  input  8  unsigned binary value, the multiplier product pp, captured on the accepted init edge.
REQ-006 busy  output  1  high while a conversion is in progress (states ADJUST, SHIFT, FIN).
REQ-007 done  output  1  registered, one-cycle pulse marking a new bcd value.
REQ-008 bcd  output  12  result as {hundreds[11:8], tens[7:4], units[3:0]}; each nibble SHALL hold a value 0-9.

Function
REQ-009 The block SHALL implement the shift-add-3 (double dabble) algorithm with a 20-bit working register W = {bcd_work[11:0], bin_work[7:0]} and a 4-bit iteration counter cnt.
REQ-010 The FSM SHALL have the states IDLE, ADJUST, SHIFT and FIN; any unused encoding SHALL go to IDLE on the next edge.
REQ-011 IDLE: with init=1, the block SHALL load W <= {12'b0, bin} and cnt <= 8, then go to ADJUST; with init=0 it SHALL stay in IDLE.
REQ-012 ADJUST (1 cycle): each of the 3 BCD nibbles of W that is >= 5 SHALL get +3 (4-bit add, no carry between nibbles); the state then goes to SHIFT.
REQ-013 SHIFT (1 cycle): the block SHALL set W <= W << 1 (zero into bit 0) and cnt <= cnt-1; if the pre-decrement cnt == 1 it goes to FIN, otherwise to ADJUST.
REQ-014 FIN (1 cycle): the block SHALL set bcd <= W[19:8] and done <= 1 on the same edge, then go to IDLE.
REQ-015 done SHALL be 0 on every edge except the FIN edge; it is high for exactly one cycle per conversion.
REQ-016 Latency: if init is accepted at edge k, done and the new bcd SHALL be visible after edge k+17 (8 ADJUST + 8 SHIFT + 1 FIN).
REQ-017 bcd SHALL hold its last value between conversions and SHALL change only on the FIN edge.
REQ-018 init=1 in ADJUST, SHIFT or FIN SHALL be ignored, with no restart and no queuing.
REQ-019 If init is held high continuously, a new conversion SHALL start on the first IDLE edge after FIN (back-to-back, with bin re-sampled).
REQ-020 bin changes after the accepted init edge SHALL NOT affect the running conversion.
REQ-021 The full input range 0-255 SHALL convert exactly; no overflow indication exists or is needed.
REQ-022 busy SHALL be combinational from state: high when state != IDLE.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set state <= IDLE, W <= 0, cnt <= 0, bcd <= 0 and done <= 0.
REQ-024 rst SHALL take priority over init and over any in-flight conversion; an aborted conversion SHALL produce no done pulse and leave bcd = 0.
REQ-025 An init asserted on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-026 The bench SHALL cover: rst, then init with bin=0 -> done pulse 17 cycles later, bcd=12'h000, busy low afterwards.
REQ-027 The bench SHALL cover: bin=8'd225 (15x15 product) -> bcd=12'h225, done high for exactly 1 cycle.
REQ-028 The bench SHALL cover: bin=8'd255 -> bcd=12'h255; then bin=8'd9 -> bcd=12'h009, with bcd stable at 12'h255 until the second FIN.
REQ-029 The bench SHALL cover: init re-pulsed and bin changed mid-conversion (bin 8'd100 -> 8'd7) -> the first result 12'h100 completes unaffected, and no extra done pulse occurs.
REQ-030 The bench SHALL cover: rst asserted during SHIFT of iteration 4 -> the next cycle has busy=0, done=0, bcd=12'h000, and no done pulse follows.
REQ-031 The bench SHALL cover: multiplier chained upstream with MR=4'd13, MD=4'd11, multiplier done driving init -> bcd=12'h143.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 8-bit binary to 3-digit BCD converter using shift-add-3 (double dabble).
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);
    typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, FIN} state_t;
    state_t      state;
    logic [19:0] w;
    logic [19:0] w_adj;
    logic [3:0]  cnt;
    function automatic logic [3:0] adj(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction
    always_comb w_adj = {adj(w[19:16]), adj(w[15:12]), adj(w[11:8]), w[7:0]};
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            w     <= '0;
            cnt   <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (init) begin
                    w     <= {12'b0, bin};
                    cnt   <= 4'd8;
                    state <= ADJUST;
                end
                ADJUST: begin
                    w     <= w_adj;
                    state <= SHIFT;
                end
                SHIFT: begin
                    w     <= {w[18:0], 1'b0};
                    cnt   <= cnt - 4'd1;
                    state <= cnt == 4'd1 ? FIN : ADJUST;
                end
                FIN: begin
                    bcd   <= w[19:8];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
